// File: rtl/touch_pad_reader.sv
// touch_pad_reader: debounces the two Fomu touch-pad pairs (active-low, pulled up)
// into a clean press state plus one-cycle press / release / long-press strobes.
// Each channel is independent: 2-flop synchronizer, 4-state debounce FSM,
// and (optionally) a saturating long-press counter.
// Optional feature macro: TOUCH_LONG_PRESS_EN builds the long-press counter;
// when it is undefined long_pulse is tied to 2'b00.
// Handshake: none; pad_n is a free-running asynchronous level, every output
// is a registered level or a single-cycle strobe with no back-pressure.
module touch_pad_reader #(
  parameter int DEBOUNCE_CYCLES = 480000,
  parameter int LONG_CYCLES     = 48000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] pad_n,
  output logic [1:0] pressed,
  output logic [1:0] press_pulse,
  output logic [1:0] release_pulse,
  output logic [1:0] long_pulse
);

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1; keep at least 1 bit.
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);

`ifdef TOUCH_LONG_PRESS_EN
  localparam int LW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [LW-1:0] LLAST = LW'(LONG_CYCLES - 1);
`endif

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_HELD         = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic          sync1_q;
    logic          s_q;
    logic [1:0]    state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          pressed_q, pressed_d;
    logic          pp_q, pp_d;
    logic          rp_q, rp_d;

    // Two-flop synchronizer; resets to the released level (1).
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_q <= 1'b1;
        s_q     <= 1'b1;
      end else begin
        sync1_q <= pad_n[i];
        s_q     <= sync1_q;
      end
    end

    // Debounce FSM next-state: a level must persist DEBOUNCE_CYCLES cycles in a WAIT state.
    always_comb begin
      state_d   = state_q;
      dcnt_d    = dcnt_q;
      pressed_d = pressed_q;
      pp_d      = 1'b0;
      rp_d      = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!s_q) begin
            state_d = ST_PRESS_WAIT;
            dcnt_d  = '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (s_q) begin
            state_d = ST_IDLE;
          end else if (dcnt_q == DLAST) begin
            state_d   = ST_HELD;
            pressed_d = 1'b1;
            pp_d      = 1'b1;
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
        ST_HELD: begin
          if (s_q) begin
            state_d = ST_RELEASE_WAIT;
            dcnt_d  = '0;
          end
        end
        ST_RELEASE_WAIT: begin
          if (!s_q) begin
            state_d = ST_HELD;
          end else if (dcnt_q == DLAST) begin
            state_d   = ST_IDLE;
            pressed_d = 1'b0;
            rp_d      = 1'b1;
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // FSM state, debounce counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q   <= ST_IDLE;
        dcnt_q    <= '0;
        pressed_q <= 1'b0;
        pp_q      <= 1'b0;
        rp_q      <= 1'b0;
      end else begin
        state_q   <= state_d;
        dcnt_q    <= dcnt_d;
        pressed_q <= pressed_d;
        pp_q      <= pp_d;
        rp_q      <= rp_d;
      end
    end

    assign pressed[i]       = pressed_q;
    assign press_pulse[i]   = pp_q;
    assign release_pulse[i] = rp_q;

`ifdef TOUCH_LONG_PRESS_EN
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic          ldone_q, ldone_d;
    logic          lp_q, lp_d;

    // Long counter: runs only in HELD, saturates, frozen in RELEASE_WAIT, cleared on press accept.
    always_comb begin
      lcnt_d  = lcnt_q;
      ldone_d = ldone_q;
      lp_d    = 1'b0;
      if (state_q == ST_HELD) begin
        if (lcnt_q == LLAST) begin
          if (!ldone_q) begin
            lp_d    = 1'b1;
            ldone_d = 1'b1;
          end
        end else begin
          lcnt_d = lcnt_q + LW'(1);
        end
      end else if ((state_q == ST_PRESS_WAIT) && !s_q && (dcnt_q == DLAST)) begin
        lcnt_d  = '0;
        ldone_d = 1'b0;
      end
    end

    // Long counter registers and the one-shot long strobe.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lcnt_q  <= '0;
        ldone_q <= 1'b0;
        lp_q    <= 1'b0;
      end else begin
        lcnt_q  <= lcnt_d;
        ldone_q <= ldone_d;
        lp_q    <= lp_d;
      end
    end

    assign long_pulse[i] = lp_q;
`else
    assign long_pulse[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_touch_pad_reader.sv
// Bench for touch_pad_reader with DEBOUNCE_CYCLES=4, LONG_CYCLES=16.
// Reference model: per channel, the pad level delayed two clocks, and a run
// length of samples disagreeing with the current press state; a run of
// DEBOUNCE_CYCLES+1 flips the state. Long press counts clocks spent pressed
// with no disagreement pending.
module tb_touch_pad_reader;
  localparam int D = 4;
  localparam int L = 16;
`ifdef TOUCH_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] pad_n;
  logic [1:0] pressed, press_pulse, release_pulse, long_pulse;

  int total = 0;
  int bad   = 0;

  touch_pad_reader #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .clk(clk), .rst(rst), .pad_n(pad_n), .pressed(pressed),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .long_pulse(long_pulse)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [1:0] m_d1, m_d2;
  logic [1:0] e_pressed, e_pp, e_rp, e_lp;
  int         m_run [2];
  int         m_hcnt [2];
  bit         m_fired [2];
  bit         m_held, m_opp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_d1 = 2'b11; m_d2 = 2'b11;
      e_pressed = 2'b00; e_pp = 2'b00; e_rp = 2'b00; e_lp = 2'b00;
      for (int c = 0; c < 2; c++) begin
        m_run[c] = 0; m_hcnt[c] = 0; m_fired[c] = 1'b0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        e_pp[c] = 1'b0; e_rp[c] = 1'b0; e_lp[c] = 1'b0;
        m_held = e_pressed[c] && (m_run[c] == 0);
        if (m_held) begin
          if (m_hcnt[c] == L - 1) begin
            if (!m_fired[c] && LONG_EN) begin
              e_lp[c] = 1'b1;
              m_fired[c] = 1'b1;
            end
          end else begin
            m_hcnt[c]++;
          end
        end
        m_opp = e_pressed[c] ? m_d2[c] : !m_d2[c];
        if (m_opp) begin
          m_run[c]++;
          if (m_run[c] == D + 1) begin
            m_run[c] = 0;
            if (e_pressed[c]) begin
              e_pressed[c] = 1'b0; e_rp[c] = 1'b1;
            end else begin
              e_pressed[c] = 1'b1; e_pp[c] = 1'b1;
              m_hcnt[c] = 0; m_fired[c] = 1'b0;
            end
          end
        end else begin
          m_run[c] = 0;
        end
      end
      m_d2 = m_d1;
      m_d1 = pad_n;
    end
  end

  // driver: release both pads and let everything settle
  task automatic settle(input int n);
    pad_n = 2'b11;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    pad_n = 2'b11;
    repeat (3) @(negedge clk);
    total++;
    if ({pressed, press_pulse, release_pulse, long_pulse} !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs got %b exp 00000000", {pressed, press_pulse, release_pulse, long_pulse});
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if ({pressed, press_pulse, release_pulse, long_pulse} !== 8'h00) begin
      bad++;
      $display("FAIL reset_idle got %b exp 00000000", {pressed, press_pulse, release_pulse, long_pulse});
    end
  endtask

  task automatic test_clean_press;
    int first = 0, npp = 0;
    pad_n[0] = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      total++;
      if ({pressed, press_pulse, release_pulse, long_pulse} !== {e_pressed, e_pp, e_rp, e_lp}) begin
        bad++;
        $display("FAIL clean_press_cyc%0d got %b exp %b", k, {pressed, press_pulse, release_pulse, long_pulse}, {e_pressed, e_pp, e_rp, e_lp});
      end
      if (press_pulse[0]) begin
        npp++;
        if (first == 0) first = k;
      end
    end
    total++;
    if (first !== 7 || npp !== 1) begin
      bad++;
      $display("FAIL clean_press_latency got edge %0d count %0d exp edge 7 count 1", first, npp);
    end
    total++;
    if (pressed !== 2'b01) begin
      bad++;
      $display("FAIL clean_press_state got %b exp 01", pressed);
    end
    settle(12);
  endtask

  task automatic test_bounce_reject;
    int npp = 0, nany = 0;
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 6; k++) begin
        pad_n[0] = (k < 3) ? 1'b0 : 1'b1;
        @(negedge clk);
        if (press_pulse | release_pulse | long_pulse | pressed) nany++;
      end
    end
    total++;
    if (nany !== 0) begin
      bad++;
      $display("FAIL bounce_quiet got %0d active cycles exp 0", nany);
    end
    pad_n[0] = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (press_pulse[0]) npp++;
      total++;
      if ({pressed, press_pulse, release_pulse, long_pulse} !== {e_pressed, e_pp, e_rp, e_lp}) begin
        bad++;
        $display("FAIL bounce_cyc%0d got %b exp %b", k, {pressed, press_pulse, release_pulse, long_pulse}, {e_pressed, e_pp, e_rp, e_lp});
      end
    end
    total++;
    if (npp !== 1) begin
      bad++;
      $display("FAIL bounce_press_count got %0d exp 1", npp);
    end
    settle(12);
  endtask

  task automatic test_long_press;
    int pk = 0, lk = 0, nl = 0, exp_lk;
    pad_n[1] = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      total++;
      if ({pressed, press_pulse, release_pulse, long_pulse} !== {e_pressed, e_pp, e_rp, e_lp}) begin
        bad++;
        $display("FAIL long_cyc%0d got %b exp %b", k, {pressed, press_pulse, release_pulse, long_pulse}, {e_pressed, e_pp, e_rp, e_lp});
      end
      if (press_pulse[1] && pk == 0) pk = k;
      if (long_pulse[1]) begin
        nl++;
        if (lk == 0) lk = k;
      end
    end
    exp_lk = LONG_EN ? 7 + L : 0;
    total++;
    if (pk !== 7 || lk !== exp_lk || nl !== (LONG_EN ? 1 : 0) || long_pulse[0] !== 1'b0) begin
      bad++;
      $display("FAIL long_timing got press %0d long %0d count %0d exp press 7 long %0d count %0d", pk, lk, nl, exp_lk, LONG_EN ? 1 : 0);
    end
    settle(12);
  endtask

  task automatic test_release_glitch;
    int nrp = 0, nl = 0;
    pad_n[0] = 1'b0;
    repeat (9) @(negedge clk);
    pad_n[0] = 1'b1;
    repeat (2) @(negedge clk);
    pad_n[0] = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (release_pulse[0]) nrp++;
      if (long_pulse[0]) nl++;
      total++;
      if ({pressed, press_pulse, release_pulse, long_pulse} !== {e_pressed, e_pp, e_rp, e_lp}) begin
        bad++;
        $display("FAIL glitch_cyc%0d got %b exp %b", k, {pressed, press_pulse, release_pulse, long_pulse}, {e_pressed, e_pp, e_rp, e_lp});
      end
    end
    total++;
    if (nrp !== 0 || nl !== (LONG_EN ? 1 : 0) || pressed[0] !== 1'b1) begin
      bad++;
      $display("FAIL glitch_hold got release %0d long %0d pressed %b exp 0 %0d 1", nrp, nl, pressed[0], LONG_EN ? 1 : 0);
    end
    pad_n[0] = 1'b1;
    nrp = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (release_pulse[0]) nrp++;
    end
    total++;
    if (nrp !== 1 || pressed[0] !== 1'b0) begin
      bad++;
      $display("FAIL glitch_release got count %0d pressed %b exp 1 0", nrp, pressed[0]);
    end
    settle(8);
  endtask

  task automatic test_simultaneous;
    int both_k = 0;
    pad_n = 2'b00;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (press_pulse == 2'b11 && both_k == 0) both_k = k;
    end
    total++;
    if (both_k !== 7 || pressed !== 2'b11) begin
      bad++;
      $display("FAIL simultaneous got edge %0d pressed %b exp edge 7 pressed 11", both_k, pressed);
    end
    settle(12);
  endtask

  task automatic test_reset_mid;
    int k0 = 0, k1 = 0, nrp = 0;
    pad_n[1] = 1'b0;
    repeat (9) @(negedge clk);
    pad_n[0] = 1'b0;
    repeat (4) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    total++;
    if ({pressed, press_pulse, release_pulse, long_pulse} !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid_async got %b exp 00000000", {pressed, press_pulse, release_pulse, long_pulse});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (release_pulse != 2'b00) nrp++;
      if (press_pulse[0] && k0 == 0) k0 = k;
      if (press_pulse[1] && k1 == 0) k1 = k;
    end
    total++;
    if (k0 !== 7 || k1 !== 7 || nrp !== 0) begin
      bad++;
      $display("FAIL reset_mid_repress got edges %0d %0d releases %0d exp 7 7 0", k0, k1, nrp);
    end
    settle(12);
  endtask

  task automatic test_random;
    int hold [2];
    hold[0] = 0; hold[1] = 0;
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < 2; c++) begin
        if (hold[c] == 0) begin
          pad_n[c] = 1'($urandom_range(0, 1));
          hold[c] = $urandom_range(1, 14);
        end
        hold[c]--;
      end
      @(negedge clk);
      total++;
      if ({pressed, press_pulse, release_pulse, long_pulse} !== {e_pressed, e_pp, e_rp, e_lp}) begin
        bad++;
        $display("FAIL random_cyc%0d got %b exp %b", k, {pressed, press_pulse, release_pulse, long_pulse}, {e_pressed, e_pp, e_rp, e_lp});
      end
    end
    settle(12);
  endtask

  initial begin
    rst = 1'b1;
    pad_n = 2'b11;
    test_reset();
    test_clean_press();
    test_bounce_reject();
    test_long_press();
    test_release_glitch();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
